// File: rtl/countdown_display_if.sv
// Signal bundle between the countdown timer and the 4-digit seven-segment display driver.
interface countdown_display_if;
    logic [4:0] count;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       timeout;

    modport master (output count, input seg, input an, input dp, input timeout);
    modport slave  (input count, output seg, output an, output dp, output timeout);
endinterface

// File: rtl/countdown_display.sv
// Multiplexed 4-digit display of a 0..31 second countdown, with a blinking "00"
// flash and a one-cycle timeout pulse when the count reaches zero.
module countdown_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_DIV     = 25000000,
    parameter int FLASH_TOGGLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    countdown_display_if.slave   bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(FLASH_TOGGLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLASH = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [1:0]    state_q, state_d;
    logic [4:0]    count_q;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] toggles_q, toggles_d;
    logic          timeout_q, timeout_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          enter;
    logic          blink_wrap;
    logic [3:0]    tens, units;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    assign tens  = 4'(count_q / 5'd10);
    assign units = 4'(count_q % 5'd10);

    always_comb begin
        blink_wrap = (blink_q == BW'(BLINK_DIV - 1));
        state_d    = state_q;
        timeout_d  = 1'b0;
        enter      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 5'd0) begin
                    state_d = S_RUN;
                    enter   = 1'b1;
                end
            end
            S_RUN: begin
                if (count_q == 5'd0) begin
                    state_d   = S_FLASH;
                    enter     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            S_FLASH: begin
                // A new nonzero count wins over the flash period running out.
                if (count_q != 5'd0) begin
                    state_d = S_RUN;
                    enter   = 1'b1;
                end else if (blink_wrap && toggles_q == TW'(FLASH_TOGGLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blink_d   = blink_q + 1'b1;
        phase_d   = phase_q;
        toggles_d = toggles_q;
        if (enter) begin
            blink_d   = '0;
            phase_d   = 1'b1;
            toggles_d = '0;
        end else if (blink_wrap) begin
            blink_d = '0;
            phase_d = ~phase_q;
            if (state_q == S_FLASH)
                toggles_d = toggles_q + 1'b1;
        end
    end

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = ~(4'b0001 << idx_q);
        if (idx_q < 2'd2) begin
            case (state_q)
                S_RUN: begin
                    if (idx_q == 2'd0)
                        seg_d = decode(units);
                    else if (tens != 4'd0)
                        seg_d = decode(tens);
                    // Blinking only kicks in for the final five seconds.
                    if (!phase_q && count_q <= 5'd5)
                        seg_d = SEG_BLANK;
                end
                S_FLASH: seg_d = phase_q ? SEG_ZERO : SEG_BLANK;
                default: seg_d = SEG_DASH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
            toggles_q <= '0;
            timeout_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= 4'b1110;
        end else begin
            state_q   <= state_d;
            count_q   <= bus.count;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            toggles_q <= toggles_d;
            timeout_q <= timeout_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.dp      = 1'b1;
    assign bus.timeout = timeout_q;
endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit-scan step (1 kHz at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink-phase toggle.
REQ-003 SHALL have parameter FLASH_TOGGLES, default 8, blink-phase toggles spent in FLASH before returning to IDLE.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port count  input  5  seconds remaining from the countdown timer; 0 when the timer is idle.
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port an  output  4  digit anodes, active-low, one-hot-low; an[0] is the rightmost digit.
REQ-009 SHALL have port dp  output  1  decimal point, active-low; held 1.
REQ-010 SHALL have port timeout  output  1  one-cycle high pulse when the countdown reaches zero.

Function
REQ-011 SHALL register count into count_q each cycle; all decisions use count_q, giving one cycle of input latency.
REQ-012 SHALL implement states IDLE, RUN and FLASH.
REQ-013 SHALL go IDLE->RUN when count_q != 0.
REQ-014 SHALL go RUN->FLASH when count_q == 0, assert timeout for exactly that one cycle, and not pulse again until RUN is re-entered.
REQ-015 SHALL go FLASH->RUN when count_q != 0 (retrigger), with priority over FLASH expiry.
REQ-016 SHALL go FLASH->IDLE after FLASH_TOGGLES blink-phase toggles.
REQ-017 SHALL compute tens = count_q/10 (0..3) and units = count_q%10 combinationally; values 0..31 are all legal.
REQ-018 Scan: refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index 0..3 SHALL increment mod 4, and an SHALL drive low only bit [index].
REQ-019 Digit content in IDLE: digits 0 and 1 SHALL show "-" (7'b0111111); digits 2 and 3 SHALL be blank (7'b1111111).
REQ-020 Digit content in RUN: digit 0 SHALL show units; digit 1 SHALL show tens, or blank when tens == 0; digits 2 and 3 SHALL be blank.
REQ-021 Digit content in FLASH: digits 0 and 1 SHALL show "0" (7'b1000000); digits 2 and 3 SHALL be blank.
REQ-022 Blink: blink counter SHALL count 0..BLINK_DIV-1; on wrap, blink_phase SHALL toggle.
REQ-023 Entry into RUN or FLASH SHALL reset the blink counter to 0 and set blink_phase to ON.
REQ-024 When blink_phase is OFF, seg SHALL be all 1s in FLASH, and in RUN when count_q <= 5; otherwise digits SHALL display steady.
REQ-025 Decode SHALL use standard active-low patterns for 0-9 (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
REQ-026 seg SHALL be a registered function of state, digit index, count_q and blink_phase, valid one cycle after any of these change.
REQ-027 A count change in RUN that stays nonzero SHALL update the displayed digits with no state change and no timeout pulse.

Reset
REQ-028 While rst_n is low, state SHALL be IDLE, count_q 0, refresh and blink counters 0, digit index 0, blink_phase ON, timeout 0, an 4'b1110, seg 7'b1111111, dp 1.
REQ-029 Reset asserted mid-RUN or mid-FLASH SHALL abort immediately with no timeout pulse; after release, the block SHALL re-evaluate count_q from IDLE.

Verification
Bench parameters: REFRESH_DIV=4, BLINK_DIV=8, FLASH_TOGGLES=4.
REQ-030 SHALL cover: reset, then count=0 for 40 cycles -> state IDLE; an cycles 1110,1101,1011,0111 every 4 cycles; seg=0111111 on digits 0 and 1, 1111111 on digits 2 and 3; timeout never high.
REQ-031 SHALL cover: count=23 -> RUN; digit 0 seg=0110000 ("3"), digit 1 seg=0100100 ("2"), no blinking over 64 cycles.
REQ-032 SHALL cover: count=7 then 4 -> digit 1 blank; digit 0 "7" steady; after 4, digit 0 shows "4" for 8 cycles and is blank for the next 8.
REQ-033 SHALL cover: count 1->0 -> timeout high exactly 1 cycle (2 cycles after the input edge); FLASH "00" blinks 4 toggles (32 cycles); then IDLE "--".
REQ-034 SHALL cover: count 0 in FLASH, then count=25 at toggle 2 -> RUN "25" steady, no extra timeout pulse.
REQ-035 SHALL cover: rst_n low for 3 cycles mid-FLASH -> outputs equal the REQ-028 values asynchronously; timeout 0; after release with count=0 -> IDLE.
